// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: accumulator FSM states, signed range constants, clog2.
package fxp_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  localparam int MAX_W = 64;

  // Largest positive two's-complement value of width w, right-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] smax(input int w);
    return (64'(1) << (w - 1)) - 64'(1);
  endfunction

  // Most negative two's-complement value of width w, right-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] smin(input int w);
    return 64'(1) << (w - 1);
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// Combinational signed saturating adder; clamps to the extreme of the operands' sign.
// Zero latency, no flow control.
module fxp_sat_add
  import fxp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam logic [MAX_W-1:0] POS64 = smax(WIDTH);
  localparam logic [MAX_W-1:0] NEG64 = smin(WIDTH);
  localparam logic [WIDTH-1:0] POS   = POS64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] NEG   = NEG64[WIDTH-1:0];

  logic [WIDTH-1:0] raw;

  // Overflow only when both operands share a sign and the result flips it.
  always_comb begin
    raw      = a + b;
    overflow = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    sum      = raw;
    if (overflow) sum = a[WIDTH-1] ? NEG : POS;
  end

endmodule

// File: rtl/fxp_mean_acc.sv
// Windowed saturating sample accumulator feeding fxp_div with sum and count<<CNT_FRAC.
// Result registered on the closing edge; HOLD blocks input until out_ready handshake.
module fxp_mean_acc
  import fxp_pkg::*;
#(
  parameter int IN_INT   = 8,
  parameter int IN_FRAC  = 8,
  parameter int SUM_INT  = 16,
  parameter int CNT_INT  = 8,
  parameter int CNT_FRAC = 8,
  parameter int MAX_CNT  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_INT+IN_FRAC-1:0]     in_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SUM_INT+IN_FRAC-1:0]    out_sum,
  output logic [CNT_INT+CNT_FRAC-1:0]   out_cnt,
  output logic                          out_sat
);

  localparam int SW = SUM_INT + IN_FRAC;
  localparam int OW = CNT_INT + CNT_FRAC;
  localparam int CW = clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_CNT);

  acc_state_t    state, state_nxt;
  logic [SW-1:0] sum, sum_add, sum_upd, sample_ext;
  logic [CW-1:0] cnt, cnt_upd;
  logic          sat, sat_upd, ovf, accept, close;

  assign sample_ext = SW'($signed(in_data));

  fxp_sat_add #(.WIDTH(SW)) u_add (
    .a        (sum),
    .b        (sample_ext),
    .sum      (sum_add),
    .overflow (ovf)
  );

  // A flush in the accept cycle sees the post-update count, so the sample lands first.
  always_comb begin
    accept  = in_valid && in_ready;
    sum_upd = accept ? sum_add : sum;
    cnt_upd = accept ? cnt + 1'b1 : cnt;
    sat_upd = sat | (accept & ovf);
    close   = (state == ACCUM) &&
              ((accept && (cnt_upd == CNT_FULL)) || (flush && (cnt_upd != '0)));
    state_nxt = state;
    case (state)
      ACCUM:   if (close) state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == ACCUM);
      out_valid <= (state_nxt == HOLD);
      if (state == HOLD) begin
        if (state_nxt == ACCUM) begin
          sum <= '0;
          cnt <= '0;
          sat <= 1'b0;
        end
      end else begin
        sum <= sum_upd;
        cnt <= cnt_upd;
        sat <= sat_upd;
        if (close) begin
          out_sum <= sum_upd;
          out_cnt <= OW'(cnt_upd) << CNT_FRAC;
          out_sat <= sat_upd;
        end
      end
    end
  end

endmodule
